// File: rtl/gemm_top.sv
// ---------------------------------------------------------------------------
// gemm_top
// Integer GEMM engine computing RESULT = alpha*(A x B) + beta*C on signed
// DATA_WIDTH-bit operands. It is free-running: every clock one RESULT element
// is computed and registered, scanning row-major and wrapping forever, so a
// full matrix refresh takes MATRIX_HEIGHT*MATRIX_WIDTH clocks.
//
// Ports
//   iclk          : clock, all logic on the rising edge
//   irst          : synchronous active-high reset (clears results and scan)
//   alpha, beta   : signed scale factors for A x B and for C
//   a_matrix      : [M][K] signed A, indexed [row][col]
//   b_matrix      : [K][N] signed B
//   c_matrix      : [M][N] signed C
//   result_matrix : [M][N] registered RESULT
// ---------------------------------------------------------------------------
module gemm_top #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4
) (
    input  logic                         iclk,
    input  logic                         irst,
    input  logic signed [DATA_WIDTH-1:0] alpha,
    input  logic signed [DATA_WIDTH-1:0] beta,
    input  logic signed [DATA_WIDTH-1:0] a_matrix      [MATRIX_HEIGHT][MATRIX_ADJUST],
    input  logic signed [DATA_WIDTH-1:0] b_matrix      [MATRIX_ADJUST][MATRIX_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] c_matrix      [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic signed [DATA_WIDTH-1:0] result_matrix [MATRIX_HEIGHT][MATRIX_WIDTH]
);

    localparam int ROW_W = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int COL_W = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MATRIX_WIDTH - 1);

    logic [ROW_W-1:0]              row;
    logic [COL_W-1:0]              col;
    logic signed [DATA_WIDTH-1:0]  dot;
    logic signed [DATA_WIDTH-1:0]  element;

    // Combinational element datapath for the currently selected (row, col).
    // Every operand is DATA_WIDTH wide, so each product and partial sum is
    // naturally truncated modulo 2^DATA_WIDTH with no saturation.
    always_comb begin
        dot = '0;
        for (int k = 0; k < MATRIX_ADJUST; k++) begin
            dot = dot + a_matrix[row][k] * b_matrix[k][col];
        end
        element = alpha * dot + beta * c_matrix[row][col];
    end

    // Result registers and row-major scan counters. Only the selected element
    // is written each clock; the rest hold. Reset overrides compute.
    always_ff @(posedge iclk) begin
        if (irst) begin
            row <= '0;
            col <= '0;
            for (int r = 0; r < MATRIX_HEIGHT; r++) begin
                for (int c = 0; c < MATRIX_WIDTH; c++) begin
                    result_matrix[r][c] <= '0;
                end
            end
        end else begin
            result_matrix[row][col] <= element;
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gemm_top.sv
// ---------------------------------------------------------------------------
// tb_gemm_top
// Self-checking bench for gemm_top. A scoreboard keeps the expected RESULT
// matrix: on every rising edge it either clears (reset) or recomputes the one
// element at the current scan position straight from the GEMM formula using
// 64-bit integer arithmetic. Directed steps also check spec-derived constants.
// ---------------------------------------------------------------------------
module tb_gemm_top;

    localparam int DW = 64;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int K  = 4;

    logic                 iclk;
    logic                 irst;
    logic signed [DW-1:0] alpha;
    logic signed [DW-1:0] beta;
    logic signed [DW-1:0] a_m [M][K];
    logic signed [DW-1:0] b_m [K][N];
    logic signed [DW-1:0] c_m [M][N];
    logic signed [DW-1:0] res [M][N];

    longint exp_m [M][N];
    int     pos;
    int     checks;
    int     failures;

    gemm_top #(
        .DATA_WIDTH   (DW),
        .MATRIX_WIDTH (N),
        .MATRIX_HEIGHT(M),
        .MATRIX_ADJUST(K)
    ) dut (
        .iclk         (iclk),
        .irst         (irst),
        .alpha        (alpha),
        .beta         (beta),
        .a_matrix     (a_m),
        .b_matrix     (b_m),
        .c_matrix     (c_m),
        .result_matrix(res)
    );

    // Free-running clock.
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Reference element straight from RESULT = alpha*(A x B) + beta*C,
    // wrapping modulo 2^64 through longint arithmetic.
    function automatic longint refElem(int r, int c);
        longint acc;
        acc = 0;
        for (int k = 0; k < K; k++) acc += longint'(a_m[r][k]) * longint'(b_m[k][c]);
        return longint'(alpha) * acc + longint'(beta) * longint'(c_m[r][c]);
    endfunction

    // Scoreboard: one element refreshed per clock in row-major order.
    always @(posedge iclk) begin
        if (irst) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) exp_m[r][c] = 0;
            pos = 0;
        end else begin
            exp_m[pos / N][pos % N] = refElem(pos / N, pos % N);
            pos = (pos + 1) % (M * N);
        end
    end

    // Advance the given number of clocks; inputs are only changed at negedge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge iclk);
    endtask

    task automatic checkValue(input string tag, input logic signed [DW-1:0] obs,
                              input logic signed [DW-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Compare every result element against the scoreboard.
    task automatic checkOutput(input string tag);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                checkValue($sformatf("%s[%0d][%0d]", tag, r, c), res[r][c], exp_m[r][c]);
    endtask

    // Wait (bounded) until the next rising edge will compute scan index target.
    task automatic waitForPos(input int target);
        int budget;
        budget = 64;
        while (pos != target && budget > 0) begin
            @(negedge iclk);
            budget--;
        end
        checks++;
        if (pos != target) begin
            failures++;
            $error("[TB] FAIL wait_pos observed=%0d expected=%0d", pos, target);
        end
    endtask

    task automatic fillRandom();
        alpha = {$urandom, $urandom};
        beta  = {$urandom, $urandom};
        for (int i = 0; i < M; i++)
            for (int j = 0; j < K; j++) a_m[i][j] = {$urandom, $urandom};
        for (int i = 0; i < K; i++)
            for (int j = 0; j < N; j++) b_m[i][j] = {$urandom, $urandom};
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) c_m[i][j] = {$urandom, $urandom};
    endtask

    task automatic fillGemm();
        alpha = 2;
        beta  = 3;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = i + j;
                b_m[i][j] = i - j;
                c_m[i][j] = 1;
            end
    endtask

    // Directed sequence.
    initial begin
        checks   = 0;
        failures = 0;
        pos      = 0;
        irst     = 1'b1;
        fillRandom();

        // Reset held for two clocks clears everything.
        applyStimulus(2);
        checkOutput("reset");
        checkValue("reset_const_33", res[3][3], 0);

        // Identity: RESULT must equal B.
        alpha = 1;
        beta  = 1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = (i == j) ? 1 : 0;
                b_m[i][j] = {$urandom, $urandom};
                c_m[i][j] = 0;
            end
        irst = 1'b0;
        applyStimulus(1);
        checkValue("ident_first_00", res[0][0], b_m[0][0]);
        checkValue("ident_first_01_hold", res[0][1], 0);
        applyStimulus(15);
        checkOutput("ident");
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                checkValue($sformatf("ident_eq_b[%0d][%0d]", i, j), res[i][j], b_m[i][j]);

        // Full GEMM with small integers.
        fillGemm();
        applyStimulus(16);
        checkOutput("gemm");
        checkValue("gemm_00_const", res[0][0], 31);

        // Negatives: all -1 gives K=4 in every element.
        alpha = 1;
        beta  = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = -1;
                b_m[i][j] = -1;
                c_m[i][j] = 0;
            end
        applyStimulus(16);
        checkOutput("neg");
        checkValue("neg_21_const", res[2][1], 4);

        // Wrap: 2^62 * 2^62 truncates to zero.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = 0;
                b_m[i][j] = 0;
            end
        a_m[0][0] = 64'sh4000_0000_0000_0000;
        b_m[0][0] = 64'sh4000_0000_0000_0000;
        applyStimulus(16);
        checkOutput("wrap");
        checkValue("wrap_00_const", res[0][0], 0);

        // Random full-width operands.
        for (int t = 0; t < 3; t++) begin
            fillRandom();
            applyStimulus(16);
            checkOutput($sformatf("rand%0d", t));
        end

        // Mid-scan change: beta drops to 0 just before (2,0) is computed.
        fillGemm();
        applyStimulus(16);
        waitForPos(8);
        beta = 0;
        applyStimulus(8);
        checkOutput("mid_half");
        checkValue("mid_row0_keeps_c", res[0][0], 31);
        checkValue("mid_row2_no_c", res[2][0], exp_m[2][0]);
        applyStimulus(8);
        checkOutput("mid_full");
        checkValue("mid_row0_no_c", res[0][0], 28);

        // Reset mid-scan at (1,2) for one clock.
        beta = 3;
        waitForPos(6);
        irst = 1'b1;
        applyStimulus(1);
        irst = 1'b0;
        checkOutput("rst_mid");
        checkValue("rst_mid_00", res[0][0], 0);
        applyStimulus(1);
        checkValue("refill_00", res[0][0], 31);
        applyStimulus(15);
        checkOutput("refill");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
